// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with single-outstanding memory port, in-order queue and redirect flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        ref_clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_DROP  = 1'b1;

    logic [0:0]    r_state;
    logic          r_armed;
    logic          r_out;
    logic [31:0]   r_pc;
    logic [31:0]   r_out_pc;
    logic [31:0]   r_q_data [QDEPTH];
    logic [31:0]   r_q_pc   [QDEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_grant;
    logic          w_rsp;
    logic          w_push;
    logic          w_out_next;
    logic [CW-1:0] w_used;

    assign inst_valid = r_count != '0;
    assign inst_data  = inst_valid ? r_q_data[r_rd] : '0;
    assign inst_pc    = inst_valid ? r_q_pc[r_rd] : '0;
    assign w_pop      = inst_valid & inst_ready;
    // slots committed after this cycle: queued entries minus the one leaving, plus the in-flight fetch
    assign w_used     = r_count - CW'(w_pop) + CW'(r_out);
    // a new fetch may go out in the same cycle the previous response lands, keeping one in flight
    assign imem_req   = r_armed & (r_state == S_FETCH) & (~r_out | imem_rvalid) & (w_used < CW'(QDEPTH));
    assign imem_addr  = r_pc;
    assign w_grant    = imem_req & imem_gnt;
    assign w_rsp      = r_out & imem_rvalid;
    assign w_push     = w_rsp & (r_state == S_FETCH) & ~redirect;
    assign w_out_next = w_grant | (r_out & ~imem_rvalid);

    // fetch PC, outstanding tracking and FETCH/DROP state; a redirect with a fetch still in flight must drop its response
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_armed  <= 1'b0;
            r_out    <= 1'b0;
            r_pc     <= RESET_PC;
            r_out_pc <= '0;
        end else begin
            r_armed  <= 1'b1;
            r_out    <= w_out_next;
            r_out_pc <= w_grant ? r_pc : r_out_pc;
            r_pc     <= redirect ? (redirect_pc & 32'hFFFF_FFFC) : w_grant ? r_pc + 32'd4 : r_pc;
            r_state  <= redirect ? (w_out_next ? S_DROP : S_FETCH)
                      : (r_state == S_DROP && w_rsp) ? S_FETCH : r_state;
        end
    end

    // queue pointers and occupancy; redirect flushes everything
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (redirect) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // queue storage: instruction word with the PC it was fetched from
    always_ff @(posedge ref_clk) begin
        if (w_push) begin
            r_q_data[r_wr] <= imem_rdata;
            r_q_pc[r_wr]   <= r_out_pc;
        end
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
Parameters:
REQ-001 RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 QDEPTH, 2, instruction queue depth; legal values 2 and 4 only.
Ports:
REQ-003 ref_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  word-aligned fetch address.
REQ-007 imem_gnt  in  1  memory accepts request this cycle.
REQ-008 imem_rvalid  in  1  read data valid.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect  in  1  branch/jump taken; flush and restart.
REQ-011 redirect_pc  in  32  restart target.
REQ-012 inst_valid  out  1  queue head valid toward decode.
REQ-013 inst_data  out  32  instruction at queue head.
REQ-014 inst_pc  out  32  PC of instruction at queue head.
REQ-015 inst_ready  in  1  decode consumes head when inst_valid is also high.

Function
REQ-016 Request accepted on a cycle with imem_req=1 and imem_gnt=1; imem_addr SHALL hold stable while imem_req=1 and imem_gnt=0.
REQ-017 At most one request outstanding; response returns in order, no earlier than the cycle after grant.
REQ-018 imem_req SHALL be asserted only if queue count + outstanding < QDEPTH and state is FETCH.
REQ-019 States: FETCH (issue/await), DROP (discard one stale response); reset enters FETCH.
REQ-020 On grant, fetch PC SHALL advance by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-021 On imem_rvalid in FETCH, {imem_rdata, PC of that request} SHALL be pushed into the queue.
REQ-022 inst_valid = queue non-empty; inst_data/inst_pc = head entry; registered, no combinational path from imem_rdata.
REQ-023 Pop occurs when inst_valid and inst_ready; simultaneous push and pop keeps count unchanged.
REQ-024 Queue full: imem_req=0; entries held unchanged; inst_ready=0 while full SHALL NOT lose or duplicate entries.
REQ-025 Redirect: next edge empties queue, loads fetch PC with {redirect_pc[31:2],2'b00}, drops any request not yet granted.
REQ-026 Redirect with response outstanding (granted, rvalid not yet seen): enter DROP; next rvalid discarded; return to FETCH same edge.
REQ-027 Redirect with rvalid in the same cycle: that response discarded, no DROP entry.
REQ-028 Redirect has priority over push, pop and grant of the same cycle; the granted address in that cycle is treated as outstanding (REQ-026).
REQ-029 Redirect while in DROP: stay in DROP, adopt new PC.
REQ-030 inst_valid SHALL be 0 the cycle after a redirect.
REQ-031 Latency: grant in cycle N, rvalid in N+1 -> inst_valid in N+2.

Reset
REQ-032 reset low SHALL immediately force: fetch PC=RESET_PC, queue empty, state FETCH, imem_req=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-033 Reset mid-operation SHALL discard outstanding responses; rvalid in the first cycle after release SHALL be ignored.
REQ-034 First imem_req SHALL assert the second cycle after reset release with imem_addr=RESET_PC.

Verification
REQ-035 Streaming: gnt=1, rvalid 1 cycle after grant, ready=1 -> inst_pc 0,4,8,C... one per cycle, data matches memory model.
REQ-036 Backpressure: ready=0 for 6 cycles -> exactly QDEPTH entries queued, imem_req=0, no loss; ready=1 -> in-order drain, fetching resumes.
REQ-037 Redirect in flight: grant at 0x10, redirect to 0x203 before rvalid -> 0x10 data dropped, next inst_pc=0x200.
REQ-038 Redirect coincident with rvalid and pop -> queue empty next cycle, inst_valid=0, next fetch at new PC.
REQ-039 Grant stall: gnt=0 for 4 cycles -> imem_addr stable at same value, no duplicate fetch.
REQ-040 Async reset asserted mid-stream between clock edges -> outputs zero immediately; after release first imem_addr=RESET_PC.
